// File: rtl/cu_pkg.sv
// Shared types and instruction field positions for the control unit.
//   opcode_t : 4-bit opcode values found in IR[15:12]
//   state_t  : 4-bit FSM state encodings (also exported on the state port)
//   *_MSB/*_LSB : bit positions of the instruction fields
//   ALU_*    : ALU operation select codes
package cu_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  // instruction field slices
  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 12;
  localparam int RA_MSB      = 11;
  localparam int RA_LSB      = 8;
  localparam int RB_MSB      = 7;
  localparam int RB_LSB      = 4;
  localparam int W_MSB       = 3;
  localparam int W_LSB       = 0;
  localparam int LD_ADDR_MSB = 11;   // LOAD data address
  localparam int LD_ADDR_LSB = 4;
  localparam int ST_ADDR_MSB = 7;    // STORE data address
  localparam int ST_ADDR_LSB = 0;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/step_sync.sv
// Single-step button conditioning: two-flop synchroniser followed by a
// rising-edge detector. Only instantiated when CU_SINGLE_STEP_EN is defined.
//   clk        : system clock
//   clear      : asynchronous active-high reset
//   step       : asynchronous push-button input
//   step_pulse : one-cycle pulse on each synchronised rising edge of step
module step_sync (
  input  logic clk,
  input  logic clear,
  input  logic step,
  output logic step_pulse
);

  logic sync1, sync2, sync_prev;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= step;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign step_pulse = sync2 & ~sync_prev;

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing controller. Drives the PC counter's up/clear,
// holds the instruction register and issues Moore control strobes to data
// memory, register file and ALU.
//
// Optional feature: define CU_SINGLE_STEP_EN to add the `step` input; the
// FSM then waits in FETCH until a synchronised step edge is seen.
//
// Ports:
//   clk, clear          : clock, asynchronous active-high reset
//   instr               : instruction-memory data at current PC
//   PC_clr, PC_up       : PC counter controls
//   IR                  : instruction register
//   D_addr, D_wr        : data-memory address / write enable
//   RF_s                : RF write-data select (1 = memory, 0 = ALU)
//   RF_W_addr, RF_W_en  : RF write port
//   RF_Ra_addr, RF_Rb_addr : RF read ports
//   ALU_s0              : ALU op (0 pass, 1 add, 2 sub)
//   halted, state       : status / debug
//   step                : single-step button (CU_SINGLE_STEP_EN only)
//
// state    | meaning
// ---------+-----------------------------------------------
// INIT  0  | clear PC
// FETCH 1  | PC_up, load IR from instr
// DECODE 2 | branch on opcode
// NOOP  3  | no operation (also any undefined opcode)
// LOAD_A 4 | present memory address, select memory data
// LOAD_B 5 | as LOAD_A plus RF write enable
// STORE 6  | write RF[Ra] to memory
// ADD   7  | RF[W] = RF[Ra] + RF[Rb]
// SUB   8  | RF[W] = RF[Ra] - RF[Rb]
// HALT  9  | halted until clear
module control_unit
  import cu_pkg::*;
#(
  parameter int IW  = 16,
  parameter int DAW = 8,
  parameter int RAW = 4
) (
  input  logic           clk,
  input  logic           clear,
  input  logic [IW-1:0]  instr,
  output logic           PC_clr,
  output logic           PC_up,
  output logic [IW-1:0]  IR,
  output logic [DAW-1:0] D_addr,
  output logic           D_wr,
  output logic           RF_s,
  output logic [RAW-1:0] RF_W_addr,
  output logic           RF_W_en,
  output logic [RAW-1:0] RF_Ra_addr,
  output logic [RAW-1:0] RF_Rb_addr,
  output logic [2:0]     ALU_s0,
  output logic           halted,
  output logic [3:0]     state
`ifdef CU_SINGLE_STEP_EN
  ,
  input  logic           step
`endif
);

  state_t        state_q, state_n;
  logic [IW-1:0] ir_q;
  logic          ir_load;
  logic          advance;
  opcode_t       op;

`ifdef CU_SINGLE_STEP_EN
  logic step_pulse;

  step_sync u_step_sync (
    .clk        (clk),
    .clear      (clear),
    .step       (step),
    .step_pulse (step_pulse)
  );

  assign advance = step_pulse;
`else
  assign advance = 1'b1;
`endif

  // undefined opcodes fall into the default branch of the decode and run as NOOP
  assign op = opcode_t'(ir_q[OP_MSB:OP_LSB]);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_n;
      if (ir_load) ir_q <= instr;
    end
  end

  always_comb begin
    state_n    = state_q;
    ir_load    = 1'b0;
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_PASS;
    halted     = 1'b0;

    case (state_q)
      S_INIT: begin
        PC_clr  = 1'b1;
        state_n = S_FETCH;
      end
      S_FETCH: begin
        if (advance) begin
          PC_up   = 1'b1;
          ir_load = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_STORE: state_n = S_STORE;
          OP_LOAD:  state_n = S_LOAD_A;
          OP_ADD:   state_n = S_ADD;
          OP_SUB:   state_n = S_SUB;
          OP_HALT:  state_n = S_HALT;
          default:  state_n = S_NOOP;
        endcase
      end
      S_NOOP: state_n = S_FETCH;
      S_LOAD_A, S_LOAD_B: begin
        D_addr    = ir_q[LD_ADDR_MSB:LD_ADDR_LSB];
        RF_s      = 1'b1;
        RF_W_addr = ir_q[W_MSB:W_LSB];
        // write only in the second cycle so memory read data has settled
        if (state_q == S_LOAD_B) begin
          RF_W_en = 1'b1;
          state_n = S_FETCH;
        end else begin
          state_n = S_LOAD_B;
        end
      end
      S_STORE: begin
        D_addr     = ir_q[ST_ADDR_MSB:ST_ADDR_LSB];
        RF_Ra_addr = ir_q[RA_MSB:RA_LSB];
        D_wr       = 1'b1;
        state_n    = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir_q[RA_MSB:RA_LSB];
        RF_Rb_addr = ir_q[RB_MSB:RB_LSB];
        RF_W_addr  = ir_q[W_MSB:W_LSB];
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
        state_n    = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_n = S_INIT;
    endcase
  end

  assign IR    = ir_q;
  assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [15:0] instr;
  logic        PC_clr, PC_up, D_wr, RF_s, RF_W_en, halted;
  logic [15:0] IR;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state;
  logic [2:0]  ALU_s0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

`ifdef CU_SINGLE_STEP_EN
  logic step = 1'b0;
  bit   auto_step = 1'b1;
  bit   manual_step = 1'b0;
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      cnt++;
      if (auto_step) begin
        if (cnt % 3 == 0) step = ~step;
      end else begin
        step = manual_step;
      end
    end
  end
`endif

  control_unit dut (
    .clk        (clk),
    .clear      (clear),
    .instr      (instr),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR         (IR),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .halted     (halted),
    .state      (state)
`ifdef CU_SINGLE_STEP_EN
    ,
    .step       (step)
`endif
  );

  // environment: 128x16 instruction memory read combinationally through a 7-bit PC
  logic [15:0] imem [128];
  logic [6:0]  pc = '0;
  assign instr = imem[pc];

  always @(posedge clk) begin
    if (PC_clr)     pc <= '0;
    else if (PC_up) pc <= pc + 7'd1;
  end

  // expected per-cycle observation
  typedef struct {
    logic [3:0]  st;
    logic        clr, up;
    logic [15:0] ir;
    logic [7:0]  da;
    logic        dwr, rfs;
    logic [3:0]  wa;
    logic        wen;
    logic [3:0]  ra, rb;
    logic [2:0]  alu;
    logic        hlt;
  } rec_t;

  rec_t q[$];
  bit   mon_en = 1'b0;

  function automatic rec_t mk(int st, logic [15:0] ir);
    rec_t r;
    r.st = 4'(st); r.clr = 0; r.up = 0; r.ir = ir; r.da = 0; r.dwr = 0;
    r.rfs = 0; r.wa = 0; r.wen = 0; r.ra = 0; r.rb = 0; r.alu = 0; r.hlt = 0;
    return r;
  endfunction

  function automatic logic [48:0] pack(rec_t r);
    return {r.st, r.clr, r.up, r.ir, r.da, r.dwr, r.rfs, r.wa, r.wen, r.ra, r.rb, r.alu, r.hlt};
  endfunction

  function automatic logic [15:0] rand_instr();
    int op = $urandom_range(0, 14);
    if (op >= 5) op++;                    // never HALT
    return {4'(op), 12'($urandom_range(0, 4095))};
  endfunction

  // Reference model: the instruction stream is imem[0], imem[1], ... (wrapping
  // at 128), one fetch per instruction; cycles per instruction come from the opcode.
  task automatic push_prog(input int n, input int halt_cycles, output int fetched);
    logic [15:0] prev = 16'h0000;
    logic [15:0] i;
    rec_t r;
    fetched = 0;
    r = mk(0, 16'h0000); r.clr = 1; q.push_back(r);
    for (int k = 0; k < n; k++) begin
      i = imem[k % 128];
      fetched++;
      r = mk(1, prev); r.up = 1; q.push_back(r);
      q.push_back(mk(2, i));
      case (i[15:12])
        4'd1: begin
          r = mk(6, i); r.da = i[7:0]; r.ra = i[11:8]; r.dwr = 1; q.push_back(r);
        end
        4'd2: begin
          r = mk(4, i); r.da = (i >> 4) & 16'hFF; r.rfs = 1; r.wa = i[3:0]; q.push_back(r);
          r.st = 5; r.wen = 1; q.push_back(r);
        end
        4'd3, 4'd4: begin
          r = mk(i[15:12] == 4'd3 ? 7 : 8, i);
          r.ra = i[11:8]; r.rb = i[7:4]; r.wa = i[3:0]; r.wen = 1;
          r.alu = (i[15:12] == 4'd3) ? 3'd1 : 3'd2;
          q.push_back(r);
        end
        4'd5: begin
          for (int h = 0; h < halt_cycles; h++) begin
            r = mk(9, i); r.hlt = 1; q.push_back(r);
          end
          return;
        end
        default: q.push_back(mk(3, i));
      endcase
      prev = i;
    end
  endtask

  // monitor: one observation per cycle, compared against the head of the queue
  always @(negedge clk) begin
    rec_t a, e;
    bit   skip;
    skip = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    if (state == 4'd1 && !PC_up && !clear) skip = 1'b1;   // waiting for a step
`endif
    if (mon_en && !skip && q.size() > 0) begin
      e = q.pop_front();
      a.st = state; a.clr = PC_clr; a.up = PC_up; a.ir = IR; a.da = D_addr;
      a.dwr = D_wr; a.rfs = RF_s; a.wa = RF_W_addr; a.wen = RF_W_en;
      a.ra = RF_Ra_addr; a.rb = RF_Rb_addr; a.alu = ALU_s0; a.hlt = halted;
      vectors++;
      if (pack(a) !== pack(e)) begin
        miscompares++;
        $display("FAIL trace exp_state=%0d act=%h exp=%h (st,clr,up,ir,da,dwr,rfs,wa,wen,ra,rb,alu,hlt)",
                 e.st, pack(a), pack(e));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic assert_clear();
    clear = 1'b1;
    #1;
    check("async_clear", {state, 3'b0, PC_clr, 3'b0, RF_W_en, 3'b0, D_wr, D_addr},
          {4'd0, 3'b0, 1'b1, 3'b0, 1'b0, 3'b0, 1'b0, 8'h00});
  endtask

  task automatic run_prog(input int n, input int halt_cycles, input int exp_pc);
    int fetched;
    mon_en = 1'b0;
    assert_clear();
    repeat (2) @(posedge clk);
    q.delete();
    push_prog(n, halt_cycles, fetched);
    @(posedge clk);
    #1 clear = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 20000 && q.size() > 0; c++) @(posedge clk);
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout act=%0d exp=0 records left", q.size());
    end
    mon_en = 1'b0;
    #1;
    check("pc_count", 32'(pc), 32'(exp_pc));
  endtask

  initial begin
    logic [15:0] dir [7];
    bit found;
    int up_cnt, add_cnt;

    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;

    // directed program: NOOP, LOAD, STORE, ADD, SUB, illegal, HALT
    dir[0] = 16'h0000; dir[1] = 16'h21A3; dir[2] = 16'h1345; dir[3] = 16'h3123;
    dir[4] = 16'h4123; dir[5] = 16'hF000; dir[6] = 16'h5000;
    for (int i = 0; i < 7; i++) imem[i] = dir[i];
    run_prog(7, 12, 7);

    // random programs ending in HALT
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 128; i++) imem[i] = rand_instr();
      imem[30] = {4'd5, 12'($urandom_range(0, 4095))};
      run_prog(31, 4, 31);
    end

    // no HALT: run past address 127 and wrap to 0
    for (int i = 0; i < 128; i++) imem[i] = rand_instr();
    run_prog(140, 0, 140 % 128);

    // clear during LOAD_A
    imem[0] = 16'h21A3;
    assert_clear();
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (state == 4'd4) found = 1'b1;
      else check("no_wen_before_load_a", 32'(RF_W_en), 32'd0);
    end
    check("reached_load_a", 32'(found), 32'd1);
    #2 clear = 1'b1;
    #1;
    check("mid_clear_state", {state, RF_W_en, RF_s, PC_clr, D_addr},
          {4'd0, 1'b0, 1'b0, 1'b1, 8'h00});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_clear_hold", {state, RF_W_en}, {4'd0, 1'b0});
    end

`ifdef CU_SINGLE_STEP_EN
    auto_step = 1'b0;
    manual_step = 1'b0;
    imem[0] = 16'h3123;
    imem[1] = 16'h5000;
    repeat (6) @(posedge clk);              // step synchroniser settles low
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);                         // INIT
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("step_wait", {state, PC_up}, {4'd1, 1'b0});
    end
    manual_step = 1'b1;
    up_cnt = 0;
    add_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (PC_up) up_cnt++;
      if (state == 4'd7) add_cnt++;
    end
    check("step_fetches", 32'(up_cnt), 32'd1);
    check("step_adds", 32'(add_cnt), 32'd1);
    check("step_after", {state, PC_up, IR}, {4'd1, 1'b0, 16'h3123});
    manual_step = 1'b0;
    auto_step = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
